// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module : tt_pkg
// Brief  : Shared constants, state encoding and width helper for the sweep.
// Rev    : 1.0
// ============================================================================
package tt_pkg;

    localparam int N_ROWS = 16;
    localparam int ROW_W  = 4;
    localparam int ONES_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // A 1-cycle hold still needs a 1-bit counter.
    function automatic int hold_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module : hold_timer
// Brief  : Counts clocks within a hold window; flags the window's last clock.
// Rev    : 1.0
// ============================================================================
module hold_timer
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int         CNT_W    = hold_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last = en && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module : tt_sweep_capture
// Brief  : Sweeps a 4-input function block through all rows and captures f.
// Rev    : 1.0
// ============================================================================
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                f_in,
    output logic                x1,
    output logic                x2,
    output logic                x3,
    output logic                x4,
    output logic                busy,
    output logic                done,
    output logic [N_ROWS-1:0]   tt,
    output logic [ONES_W-1:0]   ones
);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    idx_q,   idx_d;
    logic [N_ROWS-1:0]   tt_q,    tt_d;
    logic [ONES_W-1:0]   ones_q,  ones_d;
    logic                w_last;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .en   (state_q == RUN),
        .last (w_last)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                end
            end
            RUN: begin
                if (w_last) begin
                    tt_d[idx_q] = f_in;
                    ones_d      = ones_q + ONES_W'(f_in);
                    // idx drops back to 0 on the final row so x1..x4 read 0 in DONE.
                    if (idx_q == ROW_W'(N_ROWS - 1)) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ROW_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

    assign {x1, x2, x3, x4} = idx_q;
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);
    assign tt               = tt_q;
    assign ones             = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_tt_sweep_capture
// Brief  : Self-checking bench: HOLD=5 instance (table-driven) and HOLD=1 instance.
// Rev    : 1.0
// ============================================================================
module tb_tt_sweep_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        f_a, f_b;
    logic        x1_a, x2_a, x3_a, x4_a, busy_a, done_a;
    logic        x1_b, x2_b, x3_b, x4_b, busy_b, done_b;
    logic [15:0] tt_a, tt_b;
    logic [4:0]  ones_a, ones_b;
    int          mode_a;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  ones;
        int          done_cyc;
    } exp_t;

    typedef struct {
        int          mode;
        logic [15:0] tt;
        logic [4:0]  ones;
        bit          mid_start;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    // Function block models driven from the DUT's row outputs.
    always_comb begin
        case (mode_a)
            0:       f_a = 1'b1;
            1:       f_a = x4_a;
            2:       f_a = x1_a & x2_a;
            3:       f_a = 1'b0;
            4:       f_a = x3_a ^ x4_a;
            default: f_a = 1'b0;
        endcase
    end
    assign f_b = x3_b ^ x4_b;

    tt_sweep_capture #(.HOLD_CYCLES(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .f_in(f_a),
        .x1(x1_a), .x2(x2_a), .x3(x3_a), .x4(x4_a),
        .busy(busy_a), .done(done_a), .tt(tt_a), .ones(ones_a)
    );

    tt_sweep_capture #(.HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .f_in(f_b),
        .x1(x1_b), .x2(x2_b), .x3(x3_b), .x4(x4_b),
        .busy(busy_b), .done(done_b), .tt(tt_b), .ones(ones_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_x_a"},    {28'd0, x1_a, x2_a, x3_a, x4_a}, 32'd0);
        chk({tag, "_ctl_a"},  {30'd0, busy_a, done_a}, 32'd0);
        chk({tag, "_tt_a"},   {16'd0, tt_a}, 32'd0);
        chk({tag, "_ones_a"}, {27'd0, ones_a}, 32'd0);
        chk({tag, "_all_b"},  {x1_b, x2_b, x3_b, x4_b, busy_b, done_b, ones_b, tt_b}, 32'd0);
    endtask

    // Called on a negedge with dut_a idle; returns on a negedge.
    task automatic run_a(input vec_t v);
        exp_t e, g;
        int   c, rowerr, busyc, extra;
        bit   got;
        mode_a     = v.mode;
        e.tt       = v.tt;
        e.ones     = v.ones;
        e.done_cyc = 16 * 5 + 1;
        sbq.push_back(e);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        c = 1; rowerr = 0; busyc = 0; got = 1'b0;
        while (c <= 200 && !got) begin
            start_a = (v.mid_start && (c == 20 || c == 50)) ? 1'b1 : 1'b0;
            if (done_a) begin
                got = 1'b1;
            end else begin
                if (busy_a) busyc++;
                if ({x1_a, x2_a, x3_a, x4_a} != 4'((c - 1) / 5)) rowerr++;
                @(negedge clk);
                c++;
            end
        end
        start_a = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        g = sbq.pop_front();
        if (got) begin
            chk("done_cycle", c, g.done_cyc);
            chk("busy_cycles", busyc, 80);
            chk("row_sequence_errors", rowerr, 0);
            chk("tt", {16'd0, tt_a}, {16'd0, g.tt});
            chk("ones", {27'd0, ones_a}, {27'd0, g.ones});
            chk("done_state_x_busy", {27'd0, x1_a, x2_a, x3_a, x4_a, busy_a}, 32'd0);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a || busy_a) extra++;
        end
        chk("single_done_then_idle", extra, 0);
        chk("tt_held_idle", {16'd0, tt_a}, {16'd0, e.tt});
        chk("ones_held_idle", {27'd0, ones_a}, {27'd0, e.ones});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c, n, stray;
        exp_t e, g;

        vecs[0] = '{mode: 0, tt: 16'hFFFF, ones: 5'd16, mid_start: 1'b0};
        vecs[1] = '{mode: 1, tt: 16'hAAAA, ones: 5'd8,  mid_start: 1'b0};
        vecs[2] = '{mode: 2, tt: 16'hF000, ones: 5'd4,  mid_start: 1'b1};
        vecs[3] = '{mode: 3, tt: 16'h0000, ones: 5'd0,  mid_start: 1'b0};
        vecs[4] = '{mode: 4, tt: 16'h6666, ones: 5'd8,  mid_start: 1'b0};

        mode_a  = 0;
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b1;
        #1;
        chk_cleared("reset_init");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_a(vecs[i]);
        end

        // Asynchronous reset mid-sweep at row 7.
        mode_a  = 2;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (n < 100 && {x1_a, x2_a, x3_a, x4_a} != 4'd7) begin
            @(negedge clk);
            n++;
        end
        chk("reached_row7", {31'd0, ({x1_a, x2_a, x3_a, x4_a} == 4'd7)}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_cleared("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_a || busy_a) stray++;
        end
        chk("no_done_after_reset", stray, 0);
        run_a(vecs[2]);

        // HOLD=1 instance with start held high: two back-to-back sweeps.
        e.tt = 16'h6666; e.ones = 5'd8;
        e.done_cyc = 17; sbq.push_back(e);
        e.done_cyc = 35; sbq.push_back(e);
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c = 1; n = 0;
        while (c <= 60 && n < 2) begin
            if (done_b) begin
                g = sbq.pop_front();
                n++;
                chk("h1_done_cycle", c, g.done_cyc);
                chk("h1_tt", {16'd0, tt_b}, {16'd0, g.tt});
                chk("h1_ones", {27'd0, ones_b}, {27'd0, g.ones});
            end
            @(negedge clk);
            c++;
        end
        start_b = 1'b0;
        chk("h1_done_count", n, 2);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
